iter_muldiv: RTL
================

ITER_MULDIV -- requirements
Module: iter_muldiv

Interface
REQ-001 Parameter WIDTH, default 32: operand, HI and LO width; SHALL be even and >= 8.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req  in  1  interrupt/exception pending; when high, start and WE SHALL be ignored that cycle.
REQ-005 start  in  1  launch the operation coded on sel (MUL, MULU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU).
REQ-006 WE  in  1  write A into LO (sel=SELECT_LO) or HI (sel=SELECT_HI).
REQ-007 sel  in  4  operation / register select code.
REQ-008 A, B  in  WIDTH each  operands (A = multiplicand/dividend, B = multiplier/divisor).
REQ-009 busy  out  1  high while an operation is in flight.
REQ-010 C  out  WIDTH  read data, combinational: LO for SELECT_LO, HI for SELECT_HI, else 0; SHALL be 0 while busy.

Function
REQ-011 States: IDLE, RUN, FIX; transitions IDLE->RUN on accepted start, RUN->FIX after WIDTH iterations, FIX->IDLE after one cycle.
REQ-012 Accepted start: IDLE and !req and start and sel is an operation code; A, B, op and operand signs SHALL be latched that edge.
REQ-013 Latency: busy SHALL be high exactly WIDTH+1 cycles, starting the cycle after the accepted start edge; HI/LO updated on the FIX->IDLE edge and readable the cycle busy falls.
REQ-014 Multiply: radix-2 shift-add on magnitudes, one bit per RUN cycle; signed ops SHALL negate the 2*WIDTH product in FIX when operand signs differ.
REQ-015 MADD/MADDU: {HI,LO} SHALL become {HI,LO} + product, modulo 2^(2*WIDTH); MSUB/MSUBU: {HI,LO} - product; signed variants use signed product.
REQ-016 Divide: restoring division on magnitudes, one quotient bit per RUN cycle; FIX applies signs: quotient negative iff signs differ, remainder takes dividend sign (truncating division).
REQ-017 Divide by zero: LO SHALL be all ones, HI SHALL equal A; same latency.
REQ-018 Signed overflow (A = most-negative, B = -1): LO = most-negative, HI = 0.
REQ-019 HI/LO SHALL hold previous values during RUN/FIX; partial results live only in working registers.
REQ-020 start or WE while busy SHALL be ignored; no queuing.
REQ-021 WE and start in the same idle cycle: WE SHALL win, start dropped.
REQ-022 req high mid-operation SHALL NOT abort it; only new start/WE are masked.
REQ-023 sel codes outside the defined set with start or WE SHALL cause no state change.

Reset
REQ-024 rst high SHALL asynchronously force state IDLE, HI=0, LO=0, iteration counter=0, working registers=0, busy=0, C=0.
REQ-025 rst during RUN or FIX SHALL discard the operation; HI/LO SHALL not take partial values.
REQ-026 First start accepted on the first rising edge after rst deasserts.

Structure
REQ-027 sel codes (SELECT_LO, SELECT_HI, MUL, MULU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU) SHALL live in the shared constants include, widened to 4 bits, not in the module.
REQ-028 State encodings SHALL be localparams local to the module.
REQ-029 The per-cycle iteration datapath (one shift-add step / one restoring-subtract step) SHALL be one sub-module, muldiv_step, combinational, parametrised on WIDTH.
REQ-030 Iteration counter SHALL be $clog2(WIDTH)+1 bits.

Verification
REQ-031 WIDTH=32, MUL A=-3 B=7 -> busy 33 cycles, then HI=FFFFFFFF LO=FFFFFFEB.
REQ-032 DIV A=-7 B=2 -> LO=FFFFFFFD, HI=FFFFFFFF; DIVU A=7 B=0 -> LO=FFFFFFFF, HI=00000007.
REQ-033 WE LO=5, WE HI=0, MADDU A=4 B=3 -> LO=17, HI=0; then MSUB A=1 B=20 -> LO=FFFFFFFD, HI=FFFFFFFF.
REQ-034 start with req=1 -> busy stays 0, HI/LO unchanged; start during busy -> ignored, original result intact.
REQ-035 rst pulse at cycle 10 of DIV -> busy=0, HI=LO=0 immediately, C=0.
REQ-036 WIDTH=8, MUL A=80 B=7F -> busy 9 cycles, HI=C0 LO=80; DIV A=80 B=FF -> LO=80, HI=00.

Source files
------------

// File: rtl/iter_muldiv_pkg.sv
// Shared select/operation codes for the iterative multiply/divide unit,
// plus small decode helpers used by the unit and its bench.
package iter_muldiv_pkg;

  localparam logic [3:0] SELECT_LO = 4'd0;
  localparam logic [3:0] SELECT_HI = 4'd1;
  localparam logic [3:0] MUL       = 4'd2;
  localparam logic [3:0] MULU      = 4'd3;
  localparam logic [3:0] DIV       = 4'd4;
  localparam logic [3:0] DIVU      = 4'd5;
  localparam logic [3:0] MADD      = 4'd6;
  localparam logic [3:0] MADDU     = 4'd7;
  localparam logic [3:0] MSUB      = 4'd8;
  localparam logic [3:0] MSUBU     = 4'd9;

  function automatic logic is_op(input logic [3:0] s);
    return (s >= MUL) && (s <= MSUBU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] s);
    return (s == DIV) || (s == DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] s);
    return (s == MUL) || (s == DIV) || (s == MADD) || (s == MSUB);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the magnitude datapath: a shift-add multiply step or a
// restoring-divide step on the {hi, lo} working pair.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_s;
  logic [WIDTH:0] diff;

  always_comb begin
    sum   = {1'b0, hi_in} + (lo_in[0] ? {1'b0, opnd} : '0);
    rem_s = {hi_in, lo_in[WIDTH-1]};
    diff  = rem_s - {1'b0, opnd};
    if (is_div) begin
      // Borrow out of the trial subtract means the divisor did not fit: restore.
      if (diff[WIDTH]) begin
        hi_out = rem_s[WIDTH-1:0];
        lo_out = {lo_in[WIDTH-2:0], 1'b0};
      end else begin
        hi_out = diff[WIDTH-1:0];
        lo_out = {lo_in[WIDTH-2:0], 1'b1};
      end
    end else begin
      hi_out = sum[WIDTH:1];
      lo_out = {sum[0], lo_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/iter_muldiv.sv
// Iterative HI/LO multiply/divide unit: one bit per cycle on magnitudes,
// signs and accumulate applied in a final FIX cycle.
module iter_muldiv
  import iter_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             start,
  input  logic             WE,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] C,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   hi, lo;
  logic [WIDTH-1:0]   work_hi, work_lo, opnd;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [3:0]         op;
  logic               sign_a, sign_b;
  logic               accept, wr_ok, neg;
  logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;
  logic [2*WIDTH-1:0] prod, result;

  // Handshake: one idle cycle with !req samples WE (priority) or start;
  // anything presented while busy is dropped, never queued.
  assign wr_ok  = (state == IDLE) && !req && WE;
  assign accept = (state == IDLE) && !req && start && !WE && is_op(sel);

  assign busy      = (state != IDLE);
  assign dbg_state = state;
  assign C = busy                ? '0 :
             (sel == SELECT_LO)  ? lo :
             (sel == SELECT_HI)  ? hi : '0;

  assign a_mag = (is_signed_op(sel) && A[WIDTH-1]) ? -A : A;
  assign b_mag = (is_signed_op(sel) && B[WIDTH-1]) ? -B : B;
  assign neg   = is_signed_op(op) && (sign_a ^ sign_b);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div_op(op)),
    .hi_in  (work_hi),
    .lo_in  (work_lo),
    .opnd   (opnd),
    .hi_out (step_hi),
    .lo_out (step_lo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sign fix-up and accumulate; a zero divisor forces an all-ones quotient
  // while the remainder path already reproduces the dividend.
  always_comb begin
    prod = neg ? -{work_hi, work_lo} : {work_hi, work_lo};
    quo  = neg ? -work_lo : work_lo;
    rem  = sign_a ? -work_hi : work_hi;
    if (opnd == '0) quo = '1;
    case (op)
      MUL, MULU:   result = prod;
      MADD, MADDU: result = {hi, lo} + prod;
      MSUB, MSUBU: result = {hi, lo} - prod;
      DIV, DIVU:   result = {rem, quo};
      default:     result = {hi, lo};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi      <= '0;
      lo      <= '0;
      work_hi <= '0;
      work_lo <= '0;
      opnd    <= '0;
      op      <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_ok && sel == SELECT_LO) lo <= A;
          if (wr_ok && sel == SELECT_HI) hi <= A;
          if (accept) begin
            op      <= sel;
            sign_a  <= is_signed_op(sel) & A[WIDTH-1];
            sign_b  <= is_signed_op(sel) & B[WIDTH-1];
            cnt     <= '0;
            work_hi <= '0;
            work_lo <= is_div_op(sel) ? a_mag : b_mag;
            opnd    <= is_div_op(sel) ? b_mag : a_mag;
          end
        end
        RUN: begin
          work_hi <= step_hi;
          work_lo <= step_lo;
          cnt     <= cnt + CNT_W'(1);
        end
        FIX: begin
          {hi, lo} <= result;
          cnt      <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
